// File: rtl/vid_timing_pkg.sv
// Shared types for the raster timing generator.
//   seg_state_t : segment state of one raster axis (active, front porch, sync, back porch)
//   seg_cfg_t   : one axis' segment lengths, each encoded N-1
//   next_seg()  : fixed segment order ACT -> FP -> SYNC -> BP -> ACT
package vid_timing_pkg;

  localparam int unsigned CNT_W_DEF  = 12;
  localparam int unsigned FCNT_W_DEF = 16;

  typedef enum logic [1:0] {
    SEG_ACT  = 2'd0,
    SEG_FP   = 2'd1,
    SEG_SYNC = 2'd2,
    SEG_BP   = 2'd3
  } seg_state_t;

  typedef struct packed {
    logic [CNT_W_DEF-1:0] act;
    logic [CNT_W_DEF-1:0] fp;
    logic [CNT_W_DEF-1:0] sync;
    logic [CNT_W_DEF-1:0] bp;
  } seg_cfg_t;

  function automatic seg_state_t next_seg(input seg_state_t s);
    unique case (s)
      SEG_ACT:  next_seg = SEG_FP;
      SEG_FP:   next_seg = SEG_SYNC;
      SEG_SYNC: next_seg = SEG_BP;
      default:  next_seg = SEG_ACT;
    endcase
  endfunction

endpackage

// File: rtl/vid_axis_seq.sv
// One raster axis: four-segment FSM plus position counter inside the segment.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   clr             synchronous return to ACT/0 (generator disabled)
//   step            advance one unit (pixel for H, line for V)
//   len_act..len_bp segment lengths, encoded N-1
//   state, pos      current segment and position inside it
//   wrap            combinational: this step leaves the last unit of BP
module vid_axis_seq
  import vid_timing_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             step,
  input  logic [CNT_W-1:0] len_act,
  input  logic [CNT_W-1:0] len_fp,
  input  logic [CNT_W-1:0] len_sync,
  input  logic [CNT_W-1:0] len_bp,
  output seg_state_t       state,
  output logic [CNT_W-1:0] pos,
  output logic             wrap
);

  logic [CNT_W-1:0] seg_len;

  always_comb begin
    seg_len = len_act;
    unique case (state)
      SEG_ACT:  seg_len = len_act;
      SEG_FP:   seg_len = len_fp;
      SEG_SYNC: seg_len = len_sync;
      default:  seg_len = len_bp;
    endcase
  end

  always_comb wrap = step && (state == SEG_BP) && (pos == len_bp);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= SEG_ACT;
      pos   <= '0;
    end else if (clr) begin
      state <= SEG_ACT;
      pos   <= '0;
    end else if (step) begin
      if (pos == seg_len) begin
        pos   <= '0;
        state <= next_seg(state);
      end else begin
        pos <= pos + 1'b1;
      end
    end
  end

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing generator. Live config is copied into shadow registers only at
// a frame boundary (or immediately while disabled), so a frame never tears.
// Ports:
//   s_axi_aclk, s_axi_aresetn   clock, asynchronous active-low reset
//   pix_ce                      pixel clock enable
//   cfg_enable                  run generator (live)
//   cfg_h_*/cfg_v_*             segment lengths, encoded N-1 (shadowed)
//   cfg_hpol, cfg_vpol          sync polarity, 1 = active-high (shadowed)
//   cfg_commit                  request shadow update
//   hsync, vsync, de            registered raster outputs
//   pix_x, pix_y                active-area coordinates, 0 outside
//   frame_start, line_start     one-cycle pulses with pixel (0,0) / first pixel of line
//   commit_pending              commit requested, not yet loaded
//   frame_cnt                   completed frames, wraps
module video_timing_gen
  import vid_timing_pkg::*;
#(
  parameter int unsigned CNT_W  = CNT_W_DEF,
  parameter int unsigned FCNT_W = FCNT_W_DEF
) (
  input  logic              s_axi_aclk,
  input  logic              s_axi_aresetn,
  input  logic              pix_ce,
  input  logic              cfg_enable,
  input  logic [CNT_W-1:0]  cfg_h_act,
  input  logic [CNT_W-1:0]  cfg_h_fp,
  input  logic [CNT_W-1:0]  cfg_h_sync,
  input  logic [CNT_W-1:0]  cfg_h_bp,
  input  logic [CNT_W-1:0]  cfg_v_act,
  input  logic [CNT_W-1:0]  cfg_v_fp,
  input  logic [CNT_W-1:0]  cfg_v_sync,
  input  logic [CNT_W-1:0]  cfg_v_bp,
  input  logic              cfg_hpol,
  input  logic              cfg_vpol,
  input  logic              cfg_commit,
  output logic              hsync,
  output logic              vsync,
  output logic              de,
  output logic [CNT_W-1:0]  pix_x,
  output logic [CNT_W-1:0]  pix_y,
  output logic              frame_start,
  output logic              line_start,
  output logic              commit_pending,
  output logic [FCNT_W-1:0] frame_cnt
);

  logic [CNT_W-1:0] sh_h_act, sh_h_fp, sh_h_sync, sh_h_bp;
  logic [CNT_W-1:0] sh_v_act, sh_v_fp, sh_v_sync, sh_v_bp;
  logic             sh_hpol, sh_vpol;

  seg_state_t       h_state, v_state;
  logic [CNT_W-1:0] h_pos, v_pos;
  logic             h_wrap, v_wrap;
  logic             h_step, seq_clr;
  logic             frame_end, shadow_load, in_act;

  always_comb begin
    h_step  = pix_ce && cfg_enable;
    seq_clr = !cfg_enable;
  end

  vid_axis_seq #(.CNT_W(CNT_W)) u_h_seq (
    .clk      (s_axi_aclk),
    .rst_n    (s_axi_aresetn),
    .clr      (seq_clr),
    .step     (h_step),
    .len_act  (sh_h_act),
    .len_fp   (sh_h_fp),
    .len_sync (sh_h_sync),
    .len_bp   (sh_h_bp),
    .state    (h_state),
    .pos      (h_pos),
    .wrap     (h_wrap)
  );

  // The vertical axis steps once per line, on the last pixel of H back porch.
  vid_axis_seq #(.CNT_W(CNT_W)) u_v_seq (
    .clk      (s_axi_aclk),
    .rst_n    (s_axi_aresetn),
    .clr      (seq_clr),
    .step     (h_wrap),
    .len_act  (sh_v_act),
    .len_fp   (sh_v_fp),
    .len_sync (sh_v_sync),
    .len_bp   (sh_v_bp),
    .state    (v_state),
    .pos      (v_pos),
    .wrap     (v_wrap)
  );

  always_comb begin
    frame_end = h_wrap && v_wrap;
    // A commit arriving in the frame-end cycle loads directly and never shows as pending.
    shadow_load = (commit_pending || cfg_commit) && (frame_end || !cfg_enable);
    in_act = (h_state == SEG_ACT) && (v_state == SEG_ACT);
  end

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      sh_h_act       <= '0;
      sh_h_fp        <= '0;
      sh_h_sync      <= '0;
      sh_h_bp        <= '0;
      sh_v_act       <= '0;
      sh_v_fp        <= '0;
      sh_v_sync      <= '0;
      sh_v_bp        <= '0;
      sh_hpol        <= 1'b0;
      sh_vpol        <= 1'b0;
      commit_pending <= 1'b0;
    end else begin
      if (shadow_load) begin
        sh_h_act  <= cfg_h_act;
        sh_h_fp   <= cfg_h_fp;
        sh_h_sync <= cfg_h_sync;
        sh_h_bp   <= cfg_h_bp;
        sh_v_act  <= cfg_v_act;
        sh_v_fp   <= cfg_v_fp;
        sh_v_sync <= cfg_v_sync;
        sh_v_bp   <= cfg_v_bp;
        sh_hpol   <= cfg_hpol;
        sh_vpol   <= cfg_vpol;
        commit_pending <= 1'b0;
      end else if (cfg_commit) begin
        commit_pending <= 1'b1;
      end
    end
  end

  // Outputs describe the pixel the FSMs hold at the pix_ce that is being consumed.
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      hsync       <= 1'b0;
      vsync       <= 1'b0;
      de          <= 1'b0;
      pix_x       <= '0;
      pix_y       <= '0;
      frame_start <= 1'b0;
      line_start  <= 1'b0;
      frame_cnt   <= '0;
    end else if (!cfg_enable) begin
      hsync       <= ~sh_hpol;
      vsync       <= ~sh_vpol;
      de          <= 1'b0;
      pix_x       <= '0;
      pix_y       <= '0;
      frame_start <= 1'b0;
      line_start  <= 1'b0;
    end else if (pix_ce) begin
      hsync       <= (h_state == SEG_SYNC) ^ ~sh_hpol;
      vsync       <= (v_state == SEG_SYNC) ^ ~sh_vpol;
      de          <= in_act;
      pix_x       <= in_act ? h_pos : '0;
      pix_y       <= in_act ? v_pos : '0;
      frame_start <= in_act && (h_pos == '0) && (v_pos == '0);
      line_start  <= (h_state == SEG_ACT) && (h_pos == '0);
      if (frame_end) frame_cnt <= frame_cnt + 1'b1;
    end else begin
      frame_start <= 1'b0;
      line_start  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_video_timing_gen.sv
module tb_video_timing_gen;

  localparam int unsigned CNT_W  = 12;
  localparam int unsigned FCNT_W = 4;

  logic              clk = 1'b0;
  logic              rst_n, pix_ce, en, hpol, vpol, commit;
  logic [CNT_W-1:0]  h_act, h_fp, h_sync, h_bp, v_act, v_fp, v_sync, v_bp;
  logic              hsync, vsync, de, frame_start, line_start, commit_pending;
  logic [CNT_W-1:0]  pix_x, pix_y;
  logic [FCNT_W-1:0] frame_cnt;

  always #5 clk = ~clk;

  video_timing_gen #(.CNT_W(CNT_W), .FCNT_W(FCNT_W)) dut (
    .s_axi_aclk     (clk),
    .s_axi_aresetn  (rst_n),
    .pix_ce         (pix_ce),
    .cfg_enable     (en),
    .cfg_h_act      (h_act),
    .cfg_h_fp       (h_fp),
    .cfg_h_sync     (h_sync),
    .cfg_h_bp       (h_bp),
    .cfg_v_act      (v_act),
    .cfg_v_fp       (v_fp),
    .cfg_v_sync     (v_sync),
    .cfg_v_bp       (v_bp),
    .cfg_hpol       (hpol),
    .cfg_vpol       (vpol),
    .cfg_commit     (commit),
    .hsync          (hsync),
    .vsync          (vsync),
    .de             (de),
    .pix_x          (pix_x),
    .pix_y          (pix_y),
    .frame_start    (frame_start),
    .line_start     (line_start),
    .commit_pending (commit_pending),
    .frame_cnt      (frame_cnt)
  );

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
  endtask

  // Reference model: raster position as plain column/line indices within the frame.
  int sh[8];            // h act,fp,sync,bp, v act,fp,sync,bp (N-1 encoded)
  int sh_hp, sh_vp, m_pend, m_hc, m_vc, m_fcnt;
  int e_hs, e_vs, e_de, e_x, e_y, e_fs, e_ls;
  int cyc = 0;
  int ce_div = 1;

  function automatic int h_total();
    return sh[0] + sh[1] + sh[2] + sh[3] + 4;
  endfunction

  function automatic int v_total();
    return sh[4] + sh[5] + sh[6] + sh[7] + 4;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) sh[i] = 0;
    sh_hp = 0; sh_vp = 0; m_pend = 0; m_hc = 0; m_vc = 0; m_fcnt = 0;
    e_hs = 0; e_vs = 0; e_de = 0; e_x = 0; e_y = 0; e_fs = 0; e_ls = 0;
  endtask

  task automatic model_load();
    sh[0] = int'(h_act); sh[1] = int'(h_fp); sh[2] = int'(h_sync); sh[3] = int'(h_bp);
    sh[4] = int'(v_act); sh[5] = int'(v_fp); sh[6] = int'(v_sync); sh[7] = int'(v_bp);
    sh_hp = int'(hpol); sh_vp = int'(vpol);
    m_pend = 0;
  endtask

  task automatic model_step();
    int hs0, vs0, fend;
    if (!en) begin
      m_hc = 0; m_vc = 0;
      e_de = 0; e_x = 0; e_y = 0; e_fs = 0; e_ls = 0;
      e_hs = 1 - sh_hp; e_vs = 1 - sh_vp;
      if (m_pend != 0 || commit) model_load();
    end else if (pix_ce) begin
      hs0  = sh[0] + sh[1] + 2;
      vs0  = sh[4] + sh[5] + 2;
      e_de = (m_hc <= sh[0] && m_vc <= sh[4]) ? 1 : 0;
      e_x  = e_de ? m_hc : 0;
      e_y  = e_de ? m_vc : 0;
      e_hs = (m_hc >= hs0 && m_hc <= hs0 + sh[2]) ? sh_hp : 1 - sh_hp;
      e_vs = (m_vc >= vs0 && m_vc <= vs0 + sh[6]) ? sh_vp : 1 - sh_vp;
      e_fs = (m_hc == 0 && m_vc == 0) ? 1 : 0;
      e_ls = (m_hc == 0) ? 1 : 0;
      fend = (m_hc == h_total() - 1 && m_vc == v_total() - 1) ? 1 : 0;
      m_hc++;
      if (m_hc == h_total()) begin
        m_hc = 0;
        m_vc++;
        if (m_vc == v_total()) m_vc = 0;
      end
      if (fend != 0) begin
        m_fcnt = (m_fcnt + 1) % 16;
        if (m_pend != 0 || commit) model_load();
      end else if (commit) begin
        m_pend = 1;
      end
    end else begin
      e_fs = 0; e_ls = 0;
      if (commit) m_pend = 1;
    end
  endtask

  task automatic check_all();
    check_eq("hsync", hsync, e_hs);
    check_eq("vsync", vsync, e_vs);
    check_eq("de", de, e_de);
    check_eq("pix_x", pix_x, e_x);
    check_eq("pix_y", pix_y, e_y);
    check_eq("frame_start", frame_start, e_fs);
    check_eq("line_start", line_start, e_ls);
    check_eq("commit_pending", commit_pending, m_pend);
    check_eq("frame_cnt", frame_cnt, m_fcnt);
  endtask

  // One clock: model consumes the current inputs, DUT is sampled 1 ns after the edge.
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check_all();
    commit = 1'b0;
    cyc++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      pix_ce = (ce_div <= 1) ? 1'b1 : ((cyc % ce_div) == 0);
      tick();
    end
  endtask

  task automatic set_cfg(input int ha, hf, hs, hb, va, vf, vs, vb);
    h_act = CNT_W'(ha); h_fp = CNT_W'(hf); h_sync = CNT_W'(hs); h_bp = CNT_W'(hb);
    v_act = CNT_W'(va); v_fp = CNT_W'(vf); v_sync = CNT_W'(vs); v_bp = CNT_W'(vb);
  endtask

  task automatic async_reset();
    #1 rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    #1 rst_n = 1'b1;
  endtask

  int found, saw_wrap, fc_saved, prev_fc;

  initial begin
    rst_n = 1'b0; pix_ce = 1'b0; en = 1'b0; hpol = 1'b0; vpol = 1'b0; commit = 1'b0;
    set_cfg(0, 0, 0, 0, 0, 0, 0, 0);
    model_reset();
    #12;
    check_all();
    rst_n = 1'b1;

    // Base timing loaded while disabled: 8 px/line, 6 lines.
    set_cfg(3, 0, 1, 0, 2, 0, 0, 0);
    commit = 1'b1;
    tick();
    check_eq("pend_after_disabled_commit", commit_pending, 0);
    en = 1'b1;
    run(96);
    check_eq("fcnt_two_frames", frame_cnt, 2);

    // Mid-frame commit at cycle 10 of the frame, held pending until the frame end.
    run(10);
    h_act = 12'd7;
    commit = 1'b1;
    tick();
    check_eq("pend_set", commit_pending, 1);
    run(36);
    check_eq("pend_held", commit_pending, 1);
    run(1);
    check_eq("pend_cleared", commit_pending, 0);
    run(72);
    check_eq("fcnt_after_wide", frame_cnt, 4);

    // Commit coincident with frame end.
    h_act = 12'd3;
    found = 0;
    for (int i = 0; i < 500 && found == 0; i++) begin
      if (m_hc == h_total() - 1 && m_vc == v_total() - 1) found = 1;
      else run(1);
    end
    check_eq("seek_frame_end", found, 1);
    commit = 1'b1;
    run(1);
    check_eq("pend_coincident", commit_pending, 0);
    run(96);

    // Pixel enable every third cycle.
    ce_div = 3;
    run(300);
    ce_div = 1;

    // Disable at pixel (2,1), then re-enable.
    found = 0;
    for (int i = 0; i < 500 && found == 0; i++) begin
      if (m_hc == 2 && m_vc == 1) found = 1;
      else run(1);
    end
    check_eq("seek_pixel_2_1", found, 1);
    run(1);
    check_eq("x_at_disable", pix_x, 2);
    check_eq("y_at_disable", pix_y, 1);
    en = 1'b0;
    fc_saved = int'(frame_cnt);
    run(1);
    check_eq("de_disabled", de, 0);
    check_eq("hsync_idle", hsync, 1);
    run(5);
    en = 1'b1;
    run(1);
    check_eq("fs_reenable", frame_start, 1);
    check_eq("fcnt_kept", frame_cnt, fc_saved);

    // Active-high syncs.
    hpol = 1'b1; vpol = 1'b1;
    commit = 1'b1;
    run(150);

    // Minimal 4x4 frames to wrap the frame counter.
    set_cfg(0, 0, 0, 0, 0, 0, 0, 0);
    commit = 1'b1;
    saw_wrap = 0;
    for (int i = 0; i < 400; i++) begin
      prev_fc = int'(frame_cnt);
      run(1);
      if (prev_fc == 15 && frame_cnt == 0) saw_wrap = 1;
    end
    check_eq("fcnt_wrap", saw_wrap, 1);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      pix_ce = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 19) == 0)
        set_cfg($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
      if ($urandom_range(0, 19) == 0) begin
        hpol = $urandom_range(0, 1) == 1;
        vpol = $urandom_range(0, 1) == 1;
      end
      commit = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 299) == 0) en = ~en;
      tick();
      if ($urandom_range(0, 999) == 0) async_reset();
    end

    // Asynchronous reset mid-frame.
    en = 1'b1;
    run(13);
    async_reset();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
